// File: rtl/ec_point_encoder_if.sv
// Point-in / byte-out bundle of the SEC1 point encoder.
// The slave side is the encoder. The master side is the upstream point source plus the downstream byte sink.
interface ec_point_encoder_if #(
  parameter int COORD_BYTES = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [8*COORD_BYTES-1:0] in_x;
  logic [8*COORD_BYTES-1:0] in_y;
  logic                     in_compress;
  logic                     in_inf;
  logic                     out_valid;
  logic                     out_ready;
  logic [7:0]               out_data;
  logic                     out_last;
  logic                     busy;

  modport slave (
    input  in_valid, in_x, in_y, in_compress, in_inf, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_x, in_y, in_compress, in_inf, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/ec_point_encoder.sv
// Serialises an affine EC point into a SEC1 octet stream, one byte per beat.
// Formats: uncompressed 04||X||Y, compressed 02/03||X, and infinity 00.
module ec_point_encoder #(
  parameter int COORD_BYTES = 32,
  parameter int CNT_W       = 8
) (
  input logic            clk,
  input logic            rst_n,
  ec_point_encoder_if.slave bus
);
  localparam int W = 8 * COORD_BYTES;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COORD_BYTES - 1);
  localparam logic             ONE_BYTE = (COORD_BYTES == 1);

  typedef enum logic [1:0] {IDLE, PREFIX, XOUT, YOUT} state_t;

  state_t           state_q;
  logic [W-1:0]     x_q;
  logic [W-1:0]     y_q;
  logic             comp_q;
  logic             inf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             out_last_q;
  logic             xfer;
  logic             cnt_next_last;

  assign xfer          = out_valid_q && bus.out_ready;
  assign cnt_next_last = ((cnt_q + CNT_W'(1)) == LAST_IDX);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  // The byte on out_data is always precomputed one state ahead.
  // Each accepted byte loads the next byte and shifts the coordinate register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      comp_q      <= 1'b0;
      inf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q         <= bus.in_x;
            y_q         <= bus.in_y;
            comp_q      <= bus.in_compress;
            inf_q       <= bus.in_inf;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= PREFIX;
            if (bus.in_inf) begin
              out_data_q <= 8'h00;
              out_last_q <= 1'b1;
            end else if (bus.in_compress) begin
              out_data_q <= {7'b0000001, bus.in_y[0]};
              out_last_q <= 1'b0;
            end else begin
              out_data_q <= 8'h04;
              out_last_q <= 1'b0;
            end
          end
        end
        PREFIX: begin
          if (xfer) begin
            cnt_q <= '0;
            if (inf_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= IDLE;
            end else begin
              out_data_q <= x_q[W-1 -: 8];
              x_q        <= x_q << 8;
              out_last_q <= comp_q && ONE_BYTE;
              state_q    <= XOUT;
            end
          end
        end
        XOUT: begin
          if (xfer) begin
            if (cnt_q == LAST_IDX) begin
              cnt_q <= '0;
              if (comp_q) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                state_q     <= IDLE;
              end else begin
                out_data_q <= y_q[W-1 -: 8];
                y_q        <= y_q << 8;
                out_last_q <= ONE_BYTE;
                state_q    <= YOUT;
              end
            end else begin
              cnt_q      <= cnt_q + CNT_W'(1);
              out_data_q <= x_q[W-1 -: 8];
              x_q        <= x_q << 8;
              out_last_q <= comp_q && cnt_next_last;
            end
          end
        end
        YOUT: begin
          if (xfer) begin
            if (cnt_q == LAST_IDX) begin
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= IDLE;
            end else begin
              cnt_q      <= cnt_q + CNT_W'(1);
              out_data_q <= y_q[W-1 -: 8];
              y_q        <= y_q << 8;
              out_last_q <= cnt_next_last;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ec_point_encoder.sv
// Bench for ec_point_encoder, configured for P-256 (32-byte coordinates).
// The reference model builds the expected SEC1 octet string straight from the point.
module tb_ec_point_encoder;
  localparam int CB = 32;
  localparam int W  = 8 * CB;

  localparam logic [W-1:0] GX = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
  localparam logic [W-1:0] GY = 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]   exp_q[$];
  logic [W-1:0] b_x, b_y;
  logic         b_c, b_inf;

  ec_point_encoder_if #(.COORD_BYTES(CB)) bus ();

  ec_point_encoder #(.COORD_BYTES(CB), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_coord();
    logic [W-1:0] r;
    for (int i = 0; i < CB; i++) r[8*i +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic void build_exp(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic c, input logic inf);
    exp_q.delete();
    if (inf) begin
      exp_q.push_back(8'h00);
      return;
    end
    exp_q.push_back(c ? (y[0] ? 8'h03 : 8'h02) : 8'h04);
    for (int i = CB - 1; i >= 0; i--) exp_q.push_back(x[8*i +: 8]);
    if (!c) for (int i = CB - 1; i >= 0; i--) exp_q.push_back(y[8*i +: 8]);
  endfunction

  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic inf, input string name);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_x        = x;
    bus.in_y        = y;
    bus.in_compress = c;
    bus.in_inf      = inf;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_ready: in_ready=%b required 1", name, bus.in_ready);
    end
    build_exp(x, y, c, inf);
    @(posedge clk);
  endtask

  // mode 0: ready always high; 1: 1-on/2-off plus a 10-cycle stall at byte 20; 2: random.
  task automatic collect(input int mode, input bit b2b, input int abort_at, input string name);
    int idx, pat, stall, len;
    bit prev_hold, done, rdy;
    logic [7:0] hold_d;
    logic hold_l;
    idx = 0; pat = 0; stall = 0; prev_hold = 0; done = 0;
    hold_d = 8'h00; hold_l = 1'b0;
    len = exp_q.size();
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (b2b) begin
        bus.in_valid = 1'b1;
        bus.in_x = b_x; bus.in_y = b_y; bus.in_compress = b_c; bus.in_inf = b_inf;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_x = rand_coord(); bus.in_y = rand_coord();
        bus.in_compress = 1'($urandom); bus.in_inf = 1'($urandom);
      end
      if (cyc == 0) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s latency: out_valid=%b required 1 one cycle after accept", name, bus.out_valid);
        end
      end
      if (abort_at == idx) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_last !== 1'b0) begin
          errors++;
          $display("FAIL %s async_reset: valid=%b busy=%b ready=%b last=%b required 0 0 1 0",
                   name, bus.out_valid, bus.busy, bus.in_ready, bus.out_last);
        end
        return;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s frame_ctrl byte %0d: valid=%b busy=%b in_ready=%b required 1 1 0",
                 name, idx, bus.out_valid, bus.busy, bus.in_ready);
      end
      if (prev_hold) begin
        checks++;
        if (bus.out_data !== hold_d || bus.out_last !== hold_l) begin
          errors++;
          $display("FAIL %s stall_stable byte %0d: data=%h last=%b required %h %b",
                   name, idx, bus.out_data, bus.out_last, hold_d, hold_l);
        end
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) begin
        if (idx == 19 && stall < 10) begin
          rdy = 1'b0;
          stall++;
        end else begin
          rdy = (pat % 3 == 0);
          pat++;
        end
      end else rdy = 1'($urandom_range(0, 1));
      bus.out_ready = rdy;
      if (rdy) begin
        checks++;
        if (bus.out_data !== exp_q[idx]) begin
          errors++;
          $display("FAIL %s data byte %0d: got %h required %h", name, idx, bus.out_data, exp_q[idx]);
        end
        checks++;
        if (bus.out_last !== (idx == len - 1)) begin
          errors++;
          $display("FAIL %s last byte %0d: got %b required %b", name, idx, bus.out_last, (idx == len - 1));
        end
        idx++;
        if (idx == len) done = 1;
        prev_hold = 0;
      end else begin
        prev_hold = 1;
        hold_d = bus.out_data;
        hold_l = bus.out_last;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d bytes required %0d", name, idx, len);
    end
  endtask

  task automatic post_check(input string name);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s post_frame: valid=%b in_ready=%b busy=%b required 0 1 0",
               name, bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_x = '0; bus.in_y = '0; bus.in_compress = 1'b0; bus.in_inf = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.out_last !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h last=%b busy=%b required 1 0 00 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    post_check("reset_idle");
  endtask

  task automatic test_uncompressed();
    start(GX, GY, 1'b0, 1'b0, "uncomp_G");
    collect(0, 0, -1, "uncomp_G");
    post_check("uncomp_G");
  endtask

  task automatic test_compressed();
    start(GX, GY, 1'b1, 1'b0, "comp_G_odd");
    collect(0, 0, -1, "comp_G_odd");
    post_check("comp_G_odd");
    start(GX, {GY[W-1:1], 1'b0}, 1'b1, 1'b0, "comp_G_even");
    collect(0, 0, -1, "comp_G_even");
    post_check("comp_G_even");
  endtask

  task automatic test_infinity();
    start({W{1'b1}}, {W{1'b1}}, 1'b0, 1'b1, "infinity");
    collect(0, 0, -1, "infinity");
    post_check("infinity");
  endtask

  task automatic test_backpressure();
    start(GX, GY, 1'b0, 1'b0, "backpressure");
    collect(1, 0, -1, "backpressure");
    post_check("backpressure");
  endtask

  task automatic test_back_to_back();
    b_x = rand_coord(); b_y = rand_coord(); b_c = 1'b0; b_inf = 1'b0;
    start(GX, GY, 1'b1, 1'b0, "b2b_first");
    collect(0, 1, -1, "b2b_first");
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    build_exp(b_x, b_y, b_c, b_inf);
    collect(0, 0, -1, "b2b_second");
    post_check("b2b_second");
  endtask

  task automatic test_reset_mid_frame();
    start(GX, GY, 1'b0, 1'b0, "reset_mid");
    collect(0, 0, 29, "reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    start(GX, GY, 1'b1, 1'b0, "after_reset");
    collect(2, 0, -1, "after_reset");
    post_check("after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic c, inf;
    for (int n = 0; n < 8; n++) begin
      x = rand_coord(); y = rand_coord();
      c = 1'($urandom); inf = ($urandom_range(0, 5) == 0);
      start(x, y, c, inf, "random");
      collect(($urandom_range(0, 1) == 0) ? 0 : 2, 0, -1, "random");
      post_check("random");
    end
  endtask

  initial begin
    test_reset();
    test_uncompressed();
    test_compressed();
    test_infinity();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
